mem_responder: RTL and testbench

//  Memory-side responder for the core's instruction-fetch and load/store request interfaces.

---
 rtl/mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the instruction-fetch and load/store requesters.
// Both requesters share one single-port synchronous RAM. A data request wins over a
// simultaneous fetch, and a request in flight is never preempted. Programmable wait states
// are added after the RAM strobe. Store data is replicated across byte lanes with matching
// write enables. Load data is right-aligned so the core's sign/zero extension works on
// the low bits.
//
// Optional feature: define MISALIGN_TRAP_EN to report misaligned SH/SW/loads on
// mem_misaligned instead of forcing natural alignment. A reported access skips the RAM
// access entirely.
//
// Parameters:
//   ADDR_WIDTH  - RAM word-address width. Byte address bits [ADDR_WIDTH+1:2] are used.
//   WAIT_STATES - extra RAM cycles per access (0..7).
// Ports:
//   CLK, reset                      - clock, synchronous active-high reset
//   fetch_enable, PCfetch           - fetch request (level) and byte address
//   instr_fetch, fetch_valid        - fetched word (held) and its 1-cycle done pulse
//   memory_en, store_size           - data request (level); 00 SB, 01 SH, 10 SW, 11 load
//   mem_addr, mem_write_data        - data byte address and right-aligned store data
//   mem_read_data                   - right-aligned load word (held)
//   mem_read_data_valid             - 1-cycle load done pulse
//   mem_write_ready                 - 1-cycle store done pulse
//   ram_en, ram_we, ram_addr        - RAM strobe, byte write enables, word address
//   ram_wdata, ram_rdata            - RAM write/read data
//   mem_misaligned                  - misalignment flag (0 unless MISALIGN_TRAP_EN)

module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic [31:0]           PCfetch,
    output logic [31:0]           instr_fetch,
    output logic                  fetch_valid,
    input  logic                  memory_en,
    input  logic [1:0]            store_size,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_write_data,
    output logic [31:0]           mem_read_data,
    output logic                  mem_read_data_valid,
    output logic                  mem_write_ready,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  mem_misaligned
);

    localparam logic [2:0] WaitInit = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StResp
    } state_e;

    state_e     state;
    logic [2:0] wait_cnt;
    logic       req_fetch;
    logic       req_store;
    logic [1:0] req_off;

    // Decoded view of the data request currently on the inputs.
    logic [1:0]  off;
    logic        is_store;
    logic [3:0]  store_we;
    logic [31:0] store_wdata;
    logic        misaligned;

    // Address bits outside the RAM window are intentionally ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], PCfetch[31:ADDR_WIDTH+2],
                                PCfetch[1:0]};

    always_comb begin
        off         = mem_addr[1:0];
        is_store    = (store_size != 2'b11);
        store_we    = 4'b0000;
        store_wdata = mem_write_data;
        case (store_size)
            2'b00: begin
                store_we    = 4'b0001 << off;
                store_wdata = {4{mem_write_data[7:0]}};
            end
            2'b01: begin
                // Halfword lanes follow off[1] only, so off[0] is aligned away.
                store_we    = off[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{mem_write_data[15:0]}};
            end
            2'b10: begin
                store_we    = 4'b1111;
                store_wdata = mem_write_data;
            end
            default: begin
                store_we    = 4'b0000;
                store_wdata = mem_write_data;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        // Load width is not visible here, so any non-word-aligned load is reported.
        case (store_size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            2'b11:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
`else
        misaligned = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state               <= StIdle;
            wait_cnt            <= 3'd0;
            req_fetch           <= 1'b0;
            req_store           <= 1'b0;
            req_off             <= 2'b00;
            instr_fetch         <= 32'd0;
            fetch_valid         <= 1'b0;
            mem_read_data       <= 32'd0;
            mem_read_data_valid <= 1'b0;
            mem_write_ready     <= 1'b0;
            ram_en              <= 1'b0;
            ram_we              <= 4'b0000;
            ram_addr            <= '0;
            ram_wdata           <= 32'd0;
            mem_misaligned      <= 1'b0;
        end else begin
            // Strobes and done pulses last exactly one cycle.
            fetch_valid         <= 1'b0;
            mem_read_data_valid <= 1'b0;
            mem_write_ready     <= 1'b0;
            mem_misaligned      <= 1'b0;
            ram_en              <= 1'b0;
            ram_we              <= 4'b0000;

            case (state)
                StIdle: begin
                    if (memory_en) begin
                        req_fetch <= 1'b0;
                        req_store <= is_store;
                        req_off   <= off;
                        if (misaligned) begin
                            // No RAM access; report straight away.
                            mem_misaligned <= 1'b1;
                            if (is_store) begin
                                mem_write_ready <= 1'b1;
                            end else begin
                                mem_read_data_valid <= 1'b1;
                            end
                            state <= StResp;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= store_we;
                            ram_addr  <= mem_addr[ADDR_WIDTH+1:2];
                            ram_wdata <= store_wdata;
                            state     <= StIssue;
                        end
                    end else if (fetch_enable) begin
                        req_fetch <= 1'b1;
                        req_store <= 1'b0;
                        req_off   <= 2'b00;
                        ram_en    <= 1'b1;
                        ram_addr  <= PCfetch[ADDR_WIDTH+1:2];
                        state     <= StIssue;
                    end
                end

                StIssue: begin
                    if (WAIT_STATES != 0) begin
                        wait_cnt <= WaitInit - 3'd1;
                        state    <= StWait;
                    end else if (req_store) begin
                        mem_write_ready <= 1'b1;
                        state           <= StResp;
                    end else begin
                        state <= StCapture;
                    end
                end

                StWait: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (req_store) begin
                        mem_write_ready <= 1'b1;
                        state           <= StResp;
                    end else begin
                        state <= StCapture;
                    end
                end

                StCapture: begin
                    if (req_fetch) begin
                        instr_fetch <= ram_rdata;
                        fetch_valid <= 1'b1;
                    end else begin
                        mem_read_data       <= ram_rdata >> {req_off, 3'b000};
                        mem_read_data_valid <= 1'b1;
                    end
                    state <= StResp;
                end

                // Requests are not sampled here: the core drops them on the pulse edge.
                StResp: state <= StIdle;

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT with WAIT_STATES = 0 ----------------
    logic        reset = 1'b1;
    logic        fetch_enable = 1'b0;
    logic [31:0] PCfetch = 32'd0;
    logic [31:0] instr_fetch;
    logic        fetch_valid;
    logic        memory_en = 1'b0;
    logic [1:0]  store_size = 2'b11;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_write_data = 32'd0;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        mem_write_ready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        mem_misaligned;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut (
        .CLK(CLK), .reset(reset), .fetch_enable(fetch_enable), .PCfetch(PCfetch),
        .instr_fetch(instr_fetch), .fetch_valid(fetch_valid), .memory_en(memory_en),
        .store_size(store_size), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid),
        .mem_write_ready(mem_write_ready), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .mem_misaligned(mem_misaligned)
    );

    // Byte-lane RAM behind the first DUT.
    logic [31:0] mem [0:1023];
    always @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (ram_en) begin
            for (int l = 0; l < 4; l++)
                if (ram_we[l]) mem[ram_addr][8*l +: 8] <= ram_wdata[8*l +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- DUT with WAIT_STATES = 3 ----------------
    logic        reset_b = 1'b1;
    logic        memory_en_b = 1'b0;
    logic [31:0] mem_addr_b = 32'd0;
    logic [31:0] instr_fetch_b;
    logic        fetch_valid_b;
    logic [31:0] mem_read_data_b;
    logic        mem_read_data_valid_b;
    logic        mem_write_ready_b;
    logic        ram_en_b;
    logic [3:0]  ram_we_b;
    logic [9:0]  ram_addr_b;
    logic [31:0] ram_wdata_b;
    logic [31:0] ram_rdata_b = 32'd0;
    logic        mem_misaligned_b;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_b (
        .CLK(CLK), .reset(reset_b), .fetch_enable(1'b0), .PCfetch(32'd0),
        .instr_fetch(instr_fetch_b), .fetch_valid(fetch_valid_b), .memory_en(memory_en_b),
        .store_size(2'b11), .mem_addr(mem_addr_b), .mem_write_data(32'd0),
        .mem_read_data(mem_read_data_b), .mem_read_data_valid(mem_read_data_valid_b),
        .mem_write_ready(mem_write_ready_b), .ram_en(ram_en_b), .ram_we(ram_we_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
        .mem_misaligned(mem_misaligned_b)
    );

    // Pattern RAM: every word reads as C0DE0000 | word address.
    always @(posedge CLK) if (ram_en_b) ram_rdata_b <= 32'hC0DE_0000 | 32'(ram_addr_b);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } ram_t;

    ram_t        exp_ram[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_if[$];
    int          exp_wr[$];
    logic [31:0] exp_rd_b[$];
    int          last_ram_cyc = 0;
    int          last_ram_cyc_b = 0;
    int          ram_en_b_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    always @(negedge CLK) begin
        ram_t e;
        if (!reset) begin
            if (ram_en) begin
                last_ram_cyc = cyc;
                if (exp_ram.size() == 0) flag("ram_access");
                else begin
                    e = exp_ram.pop_front();
                    check("ram_we", 32'(ram_we), 32'(e.we));
                    check("ram_addr", 32'(ram_addr), 32'(e.addr));
                    if (e.we != 4'b0000) check("ram_wdata", ram_wdata, e.wdata);
                end
            end else if (ram_we != 4'b0000) flag("ram_we_outside_issue");
            if (32'(fetch_valid) + 32'(mem_read_data_valid) + 32'(mem_write_ready) > 1)
                flag("pulse_overlap");
            if (mem_read_data_valid) begin
                if (exp_rd.size() == 0) flag("mem_read_data_valid");
                else check("mem_read_data", mem_read_data, exp_rd.pop_front());
            end
            if (fetch_valid) begin
                if (exp_if.size() == 0) flag("fetch_valid");
                else check("instr_fetch", instr_fetch, exp_if.pop_front());
            end
            if (mem_write_ready) begin
                if (exp_wr.size() == 0) flag("mem_write_ready");
                else void'(exp_wr.pop_front());
            end
            if (mem_misaligned) flag("mem_misaligned");
        end
        if (!reset_b) begin
            if (ram_en_b) begin
                ram_en_b_cnt++;
                last_ram_cyc_b = cyc;
            end
            if (mem_read_data_valid_b) begin
                if (exp_rd_b.size() == 0) flag("b_mem_read_data_valid");
                else check("b_mem_read_data", mem_read_data_b, exp_rd_b.pop_front());
            end
            if (fetch_valid_b || mem_write_ready_b) flag("b_other_pulse");
        end
    end

    function automatic bit done_pulse(input bit f, input bit s);
        return f ? fetch_valid : (s ? mem_write_ready : mem_read_data_valid);
    endfunction

    // One request to the first DUT; expected RAM access and response are queued up front.
    task automatic req(input string name, input bit fetch, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] xwe, input logic [9:0] xaddr,
                       input logic [31:0] xwdata, input logic [31:0] xrd, input bit hold);
        int   c0;
        int   n;
        int   lat;
        bit   is_store;
        ram_t e;
        is_store = !fetch && (size != 2'b11);
        lat      = is_store ? 2 : 3;
        e.we = xwe; e.addr = xaddr; e.wdata = xwdata;
        exp_ram.push_back(e);
        if (fetch) exp_if.push_back(xrd);
        else if (is_store) exp_wr.push_back(1);
        else exp_rd.push_back(xrd);
        @(negedge CLK);
        c0 = cyc;
        if (fetch) begin
            fetch_enable = 1'b1; PCfetch = addr;
        end else begin
            memory_en = 1'b1; store_size = size; mem_addr = addr; mem_write_data = data;
        end
        if (!hold) begin
            // Drop and scramble the request once it has been sampled.
            @(negedge CLK);
            fetch_enable = 1'b0; memory_en = 1'b0; PCfetch = 32'hFFFF_FFFF;
            mem_addr = 32'hFFFF_FFFF; mem_write_data = 32'h0BAD_0BAD; store_size = 2'b10;
        end
        n = 0;
        while (!done_pulse(fetch, is_store) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) flag({name, " timeout"});
        else begin
            check({name, " latency"}, 32'(cyc - c0), 32'(lat));
            check({name, " ram_en cycle"}, 32'(last_ram_cyc - c0), 32'd1);
        end
        fetch_enable = 1'b0; memory_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        ram_t e;
        repeat (3) @(negedge CLK);
        reset = 1'b0; reset_b = 1'b0;
        @(negedge CLK);
        check("reset ctrl", 32'({fetch_valid, mem_read_data_valid, mem_write_ready, ram_en,
                                  ram_we, mem_misaligned}), 32'd0);
        check("reset instr_fetch", instr_fetch, 32'd0);
        check("reset mem_read_data", mem_read_data, 32'd0);
        check("reset ram_addr", 32'(ram_addr), 32'd0);
        check("reset ram_wdata", ram_wdata, 32'd0);

        req("SW 0x10", 0, 2'b10, 32'h10, 32'hDEAD_BEEF, 4'hF, 10'd4, 32'hDEAD_BEEF, 0, 1);
        req("SB 0x13", 0, 2'b00, 32'h13, 32'h0000_00A5, 4'h8, 10'd4, 32'hA5A5_A5A5, 0, 1);
        req("LW 0x10", 0, 2'b11, 32'h10, 0, 4'h0, 10'd4, 0, 32'hA5AD_BEEF, 1);
        req("LB 0x13", 0, 2'b11, 32'h13, 0, 4'h0, 10'd4, 0, 32'h0000_00A5, 0);
        req("SH 0x16", 0, 2'b01, 32'h16, 32'h0000_1234, 4'hC, 10'd5, 32'h1234_1234, 0, 1);
        req("LH 0x16", 0, 2'b11, 32'h16, 0, 4'h0, 10'd5, 0, 32'h0000_1234, 1);
        req("SW 0x1B", 0, 2'b10, 32'h1B, 32'h0102_0304, 4'hF, 10'd6, 32'h0102_0304, 0, 1);
        req("SH 0x1D", 0, 2'b01, 32'h1D, 32'h0000_BEEF, 4'h3, 10'd7, 32'hBEEF_BEEF, 0, 1);
        req("LW 0x1C", 0, 2'b11, 32'h1C, 0, 4'h0, 10'd7, 0, 32'h0000_BEEF, 1);
        req("SB wrap", 0, 2'b00, 32'h1010, 32'h0000_0077, 4'h1, 10'd4, 32'h7777_7777, 0, 0);
        req("LW 0x1011", 0, 2'b11, 32'h1011, 0, 4'h0, 10'd4, 0, 32'h00A5_ADBE, 1);
        req("SB 0x12", 0, 2'b00, 32'h12, 32'hFFFF_FF3C, 4'h4, 10'd4, 32'h3C3C_3C3C, 0, 1);
        req("LH 0x12", 0, 2'b11, 32'h12, 0, 4'h0, 10'd4, 0, 32'h0000_A53C, 1);
        req("fetch 0x10", 1, 2'b00, 32'h10, 0, 4'h0, 10'd4, 0, 32'hA53C_BE77, 1);

        // Fetch and load raised together: load first, fetch sampled in the following IDLE.
        e.we = 4'h0; e.addr = 10'd5; e.wdata = 0; exp_ram.push_back(e);
        e.addr = 10'd6; exp_ram.push_back(e);
        exp_rd.push_back(32'h1234_0000);
        exp_if.push_back(32'h0102_0304);
        @(negedge CLK);
        c0 = cyc;
        memory_en = 1'b1; store_size = 2'b11; mem_addr = 32'h14;
        fetch_enable = 1'b1; PCfetch = 32'h1A;
        n = 0;
        while (!mem_read_data_valid && n < 20) begin @(negedge CLK); n++; end
        if (n >= 20) flag("dual load timeout");
        else check("dual load latency", 32'(cyc - c0), 32'd3);
        memory_en = 1'b0;
        n = 0;
        while (!fetch_valid && n < 20) begin @(negedge CLK); n++; end
        if (n >= 20) flag("dual fetch timeout");
        else check("dual fetch latency", 32'(cyc - c0), 32'd7);
        fetch_enable = 1'b0;
        repeat (4) @(negedge CLK);
        check("instr_fetch held", instr_fetch, 32'h0102_0304);
        check("mem_read_data held", mem_read_data, 32'h1234_0000);

        // WAIT_STATES = 3 load.
        ram_en_b_cnt = 0;
        exp_rd_b.push_back(32'hC0DE_0009);
        @(negedge CLK);
        c0 = cyc;
        memory_en_b = 1'b1; mem_addr_b = 32'h24;
        n = 0;
        while (!mem_read_data_valid_b && n < 20) begin @(negedge CLK); n++; end
        if (n >= 20) flag("WS3 load timeout");
        else check("WS3 load latency", 32'(cyc - c0), 32'd6);
        memory_en_b = 1'b0;
        check("WS3 ram_en count", 32'(ram_en_b_cnt), 32'd1);
        check("WS3 ram_en cycle", 32'(last_ram_cyc_b - c0), 32'd1);

        // Reset during the first WAIT cycle of a load.
        @(negedge CLK);
        memory_en_b = 1'b1; mem_addr_b = 32'h28;
        repeat (2) @(negedge CLK);
        memory_en_b = 1'b0; reset_b = 1'b1;
        @(negedge CLK);
        reset_b = 1'b0;
        check("mid reset ctrl", 32'({fetch_valid_b, mem_read_data_valid_b, mem_write_ready_b,
                                      ram_en_b, ram_we_b, mem_misaligned_b}), 32'd0);
        check("mid reset mem_read_data", mem_read_data_b, 32'd0);
        check("mid reset ram_addr", 32'(ram_addr_b), 32'd0);
        check("mid reset instr_fetch", instr_fetch_b, 32'd0);
        repeat (8) @(negedge CLK);
        exp_rd_b.push_back(32'hC0DE_000A);
        c0 = cyc;
        memory_en_b = 1'b1; mem_addr_b = 32'h28;
        n = 0;
        while (!mem_read_data_valid_b && n < 20) begin @(negedge CLK); n++; end
        if (n >= 20) flag("post reset load timeout");
        else check("post reset load latency", 32'(cyc - c0), 32'd6);
        memory_en_b = 1'b0;

        repeat (4) @(negedge CLK);
        check("queues drained", 32'(exp_ram.size() + exp_rd.size() + exp_if.size()
                                    + exp_wr.size() + exp_rd_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
